pix_pack_writer: RTL and testbench
==================================

Name: pix_pack_writer

Overview:
Write-side feeder for the 16-bit asynchronous FIFO in the sensor clock domain. It captures one frame of 12-bit pixels and packs them little-endian into 16-bit words, so that 4 pixels become 3 words. It drives the FIFO write handshake through a 2-entry output queue. The sensor cannot be stalled, so backpressure beyond the queue depth is reported as a sticky overflow.

Parameters:
CNT_W, 24, width of the emitted-word counter; saturates at all-ones.

Ports:
rst_  in  1  reset, asynchronous, active-low
w_clk  in  1  pixel/write clock
en  in  1  capture enable; level; low aborts to IDLE
pix_fv  in  1  frame valid from sensor
pix_valid  in  1  pixel strobe; ignored unless pix_fv=1
pix_data  in  12  pixel value
fifo_trigger  out  1  write strobe to FIFO (queue non-empty)
fifo_data  out  16  queue head word
fifo_ready  in  1  FIFO not full
done  out  1  frame captured and queue drained; held until en falls
overflow  out  1  sticky: pixel lost because queue full
word_count  out  CNT_W  words pushed into queue this capture

Behaviour:
- Reset (async, rst_=0): state=IDLE, bit buffer empty (fill=0), queue empty, fifo_trigger=0, fifo_data=0, done=0, overflow=0, word_count=0.
- States:
  - IDLE: if en=1, go to WAIT_FS; clear overflow and word_count on that transition.
  - WAIT_FS: wait for a rising edge of pix_fv (registered pix_fv 0 -> 1). A frame already in progress when en rises is skipped. On the edge, go to CAPTURE; the pixel on that same cycle is accepted.
  - CAPTURE: accept pixels. On pix_fv falling, go to FLUSH.
  - FLUSH: if fill>0, push one padded word. Wait for the queue to empty, then go to DONE.
  - DONE: done=1; stay until en=0.
- en=0 in any state: next state IDLE; buffer and queue cleared; done=0. overflow and word_count hold their values until the next en rise.
- Packing:
  - 28-bit bit buffer; each accepted pixel is appended at bit position fill, and fill += 12.
  - If fill >= 16 after append, the low 16 bits are pushed, the buffer shifts right 16, and fill -= 16.
  - fill cycles through 0, 12, 8, 4, 0. At most one push per cycle.
- Flush word: low fill bits of the buffer, upper bits zero.
- Queue:
  - 2 entries. fifo_trigger = head valid. fifo_data = head word, or 0 when empty.
  - Pop when fifo_trigger && fifo_ready.
  - Push and pop in the same cycle are both allowed; with a full queue this is legal (no overflow).
- Latency: a completing pixel at cycle t gives fifo_trigger=1 with that word at t+1 if the queue was empty.
- Overflow:
  - Condition: a push is required while the queue is full and no pop occurs this cycle.
  - Response: the word is dropped, overflow=1 (sticky), and the state goes to DONE after the queue drains. No FLUSH word is emitted.
- word_count increments on each successful push and saturates at 2^CNT_W-1.
- pix_valid while pix_fv=0, or in any state other than CAPTURE, is ignored.
- Simultaneous pix_fv fall and last pixel in the same cycle: the pixel is accepted first, then FLUSH is entered.

Decomposition:
- Shared package/include: pixel width 12, word width 16, and state encodings (IDLE, WAIT_FS, CAPTURE, FLUSH, DONE).
- One sub-module: pix_pack_queue2, a 2-entry FIFO with push, pop, full, empty and head outputs and a synchronous clear; it is reused for other sensor feeders.
- The packer and FSM remain in the top module.

Test Plan:
- Basic packing: en=1, fv rise, pixels 0xABC, 0x123, 0x456, 0x789, fv fall, fifo_ready=1 -> FIFO sees 0x3ABC, 0x5612, 0x7894; word_count=3; done=1; overflow=0.
- Flush: same stream plus a 5th pixel 0xDEF -> 4th word 0x0DEF; word_count=4; done only after the 4th pop.
- Backpressure: fifo_ready=0 while 8 pixels arrive back-to-back -> 2 words queued, 3rd push drops, overflow=1, word_count=2. Raise fifo_ready -> 0x3ABC and 0x5612 pop out, then done=1.
- Late enable: en rises mid-frame (fv=1) -> nothing captured until the next fv rise; that frame then packs correctly from its first pixel.
- Abort: en=0 mid-CAPTURE with 1 word queued -> next cycle fifo_trigger=0, state IDLE. Re-enable -> overflow=0 and word_count=0 after the en rise.
- Async reset: assert rst_ mid-frame between clock edges -> all outputs 0 immediately; no write strobes until a new fv rise after rst_ release and en=1.

Source files
------------

// File: rtl/pix_pack_writer_pkg.sv
// Shared widths and FSM encoding for the sensor-side pixel packers.
package pix_pack_writer_pkg;

  localparam int PIX_W  = 12;
  localparam int WORD_W = 16;
  localparam int BUF_W  = 28;
  localparam int FILL_W = 5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_FS = 3'd1,
    CAPTURE = 3'd2,
    FLUSH   = 3'd3,
    DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/pix_pack_queue2.sv
// Two-entry word queue with synchronous clear; head is entry 0.
module pix_pack_queue2
  import pix_pack_writer_pkg::*;
(
  input  logic              w_clk,
  input  logic              rst_,
  input  logic              i_clr,
  input  logic              i_push,
  input  logic [WORD_W-1:0] i_din,
  input  logic              i_pop,
  output logic              o_full,
  output logic              o_empty,
  output logic [WORD_W-1:0] o_head
);

  logic [WORD_W-1:0] r_q0;
  logic [WORD_W-1:0] r_q1;
  logic [1:0]        r_cnt;
  logic              w_pop_ok;
  logic              w_push_ok;

  assign w_pop_ok  = i_pop && (r_cnt != 2'd0);
  assign w_push_ok = i_push && ((r_cnt != 2'd2) || w_pop_ok);

  // Storage update: push fills the first free slot, pop shifts entry 1 forward.
  always_ff @(posedge w_clk or negedge rst_) begin
    if (!rst_) begin
      r_q0  <= '0;
      r_q1  <= '0;
      r_cnt <= 2'd0;
    end else if (i_clr) begin
      r_q0  <= '0;
      r_q1  <= '0;
      r_cnt <= 2'd0;
    end else begin
      case ({w_push_ok, w_pop_ok})
        2'b10: begin
          if (r_cnt == 2'd0) r_q0 <= i_din;
          else               r_q1 <= i_din;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_q0  <= r_q1;
          r_q1  <= '0;
          r_cnt <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_q0 <= i_din;
          end else begin
            r_q0 <= r_q1;
            r_q1 <= i_din;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_full  = (r_cnt == 2'd2);
  assign o_empty = (r_cnt == 2'd0);
  assign o_head  = r_q0;

endmodule

// File: rtl/pix_pack_writer.sv
// Captures one frame of 12-bit pixels, packs them little-endian into 16-bit
// words and feeds the async FIFO through a 2-entry queue.
//
// state   | meaning
// IDLE    | disabled, buffer and queue empty
// WAIT_FS | enabled, waiting for a fresh frame-valid rise
// CAPTURE | accepting pixels until frame-valid drops
// FLUSH   | emit padded partial word (unless overflowed), drain queue
// DONE    | frame complete, hold done until en falls
module pix_pack_writer
  import pix_pack_writer_pkg::*;
#(
  parameter int CNT_W = 24
) (
  input  logic              rst_,
  input  logic              w_clk,
  input  logic              en,
  input  logic              pix_fv,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              fifo_trigger,
  output logic [WORD_W-1:0] fifo_data,
  input  logic              fifo_ready,
  output logic              done,
  output logic              overflow,
  output logic [CNT_W-1:0]  word_count
);

  state_t            r_state;
  logic              r_fv_d;
  logic [BUF_W-1:0]  r_buf;
  logic [FILL_W-1:0] r_fill;
  logic              r_done;
  logic              r_overflow;
  logic [CNT_W-1:0]  r_word_count;

  logic              w_full;
  logic              w_empty;
  logic [WORD_W-1:0] w_head;
  logic              w_pop;
  logic              w_fv_rise;
  logic              w_accept;
  logic [BUF_W-1:0]  w_buf_app;
  logic [FILL_W-1:0] w_fill_app;
  logic              w_pix_push;
  logic              w_pad_push;
  logic              w_push_req;
  logic [WORD_W-1:0] w_push_data;
  logic              w_room;
  logic              w_push_ok;
  logic              w_drop;

  assign w_pop     = !w_empty && fifo_ready;
  assign w_fv_rise = pix_fv && !r_fv_d;

  // The pixel that arrives with the frame-valid rise belongs to the frame.
  assign w_accept = en && pix_valid && pix_fv &&
                    ((r_state == CAPTURE) || ((r_state == WAIT_FS) && w_fv_rise));

  assign w_buf_app  = r_buf | (BUF_W'(pix_data) << r_fill);
  assign w_fill_app = r_fill + 5'd12;

  assign w_pix_push  = w_accept && (w_fill_app >= 5'd16);
  assign w_pad_push  = en && (r_state == FLUSH) && (r_fill != '0);
  assign w_push_req  = w_pix_push || w_pad_push;
  // Bits above fill are always zero, so the low half is already the padded word.
  assign w_push_data = w_pix_push ? w_buf_app[WORD_W-1:0] : r_buf[WORD_W-1:0];

  // A pop in the same cycle frees a slot even when the queue is full.
  assign w_room    = !w_full || w_pop;
  assign w_push_ok = w_push_req && w_room;
  assign w_drop    = w_pix_push && !w_room;

  pix_pack_queue2 u_queue (
    .w_clk   (w_clk),
    .rst_    (rst_),
    .i_clr   (!en),
    .i_push  (w_push_ok),
    .i_din   (w_push_data),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  // Sequencing FSM together with the bit buffer and the status registers.
  always_ff @(posedge w_clk or negedge rst_) begin
    if (!rst_) begin
      r_state      <= IDLE;
      r_fv_d       <= 1'b0;
      r_buf        <= '0;
      r_fill       <= '0;
      r_done       <= 1'b0;
      r_overflow   <= 1'b0;
      r_word_count <= '0;
    end else begin
      r_fv_d <= pix_fv;
      if (!en) begin
        r_state <= IDLE;
        r_buf   <= '0;
        r_fill  <= '0;
        r_done  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state      <= WAIT_FS;
            r_overflow   <= 1'b0;
            r_word_count <= '0;
          end
          WAIT_FS: if (w_fv_rise) r_state <= CAPTURE;
          CAPTURE: if (!pix_fv) r_state <= FLUSH;
          FLUSH: begin
            if ((r_fill == '0) && w_empty) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
          DONE:    ;
          default: r_state <= IDLE;
        endcase

        if (w_accept) begin
          if (w_drop) begin
            // Lost word: discard the partial buffer so FLUSH only drains.
            r_buf      <= '0;
            r_fill     <= '0;
            r_overflow <= 1'b1;
            r_state    <= FLUSH;
          end else if (w_pix_push) begin
            r_buf  <= w_buf_app >> WORD_W;
            r_fill <= w_fill_app - 5'd16;
          end else begin
            r_buf  <= w_buf_app;
            r_fill <= w_fill_app;
          end
        end else if (w_pad_push && w_push_ok) begin
          r_buf  <= '0;
          r_fill <= '0;
        end

        if (w_push_ok && (r_word_count != '1)) begin
          r_word_count <= r_word_count + CNT_W'(1);
        end
      end
    end
  end

  assign fifo_trigger = !w_empty;
  assign fifo_data    = w_empty ? '0 : w_head;
  assign done         = r_done;
  assign overflow     = r_overflow;
  assign word_count   = r_word_count;

endmodule

// File: tb/tb_pix_pack_writer.sv
// Directed and randomized checks of pix_pack_writer against a bit-stream model.
module tb_pix_pack_writer;

  localparam int CNT_W = 24;

  logic             rst_;
  logic             w_clk;
  logic             en;
  logic             pix_fv;
  logic             pix_valid;
  logic [11:0]      pix_data;
  logic             fifo_trigger;
  logic [15:0]      fifo_data;
  logic             fifo_ready;
  logic             done;
  logic             overflow;
  logic [CNT_W-1:0] word_count;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [11:0] exp_pix[$];
  logic [15:0] got[$];

  pix_pack_writer #(.CNT_W(CNT_W)) dut (
    .rst_         (rst_),
    .w_clk        (w_clk),
    .en           (en),
    .pix_fv       (pix_fv),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .fifo_trigger (fifo_trigger),
    .fifo_data    (fifo_data),
    .fifo_ready   (fifo_ready),
    .done         (done),
    .overflow     (overflow),
    .word_count   (word_count)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  // Record every word the FIFO accepts (handshake is stable at the negedge).
  always @(negedge w_clk) begin
    if (rst_ === 1'b1 && fifo_trigger === 1'b1 && fifo_ready === 1'b1)
      got.push_back(fifo_data);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge w_clk);
    #1;
  endtask

  task automatic put_pixel(input logic [11:0] p);
    pix_fv    = 1'b1;
    pix_valid = 1'b1;
    pix_data  = p;
    exp_pix.push_back(p);
    tick();
  endtask

  task automatic gap_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      pix_fv    = 1'b1;
      pix_valid = 1'b0;
      pix_data  = 12'($urandom);
      tick();
    end
  endtask

  task automatic end_frame();
    pix_fv    = 1'b0;
    pix_valid = 1'b0;
    tick();
  endtask

  // Disable, re-enable, and wiggle pix_valid outside a frame (must be ignored).
  task automatic start_capture();
    en = 1'b0; pix_fv = 1'b0; pix_valid = 1'b0; pix_data = '0;
    tick();
    en = 1'b1;
    tick();
    pix_valid = 1'b1; pix_data = 12'($urandom);
    tick();
    pix_valid = 1'b0;
    tick();
    exp_pix.delete();
    got.delete();
  endtask

  // Word k of the concatenated little-endian pixel bit stream, zero padded.
  function automatic logic [15:0] model_word(input int k);
    logic [15:0] w;
    logic [11:0] p;
    w = '0;
    for (int b = 0; b < 16; b++) begin
      int pos;
      int idx;
      pos = 16 * k + b;
      idx = pos / 12;
      if (idx < exp_pix.size()) begin
        p    = exp_pix[idx];
        w[b] = p[pos % 12];
      end
    end
    return w;
  endfunction

  function automatic int exp_words();
    return (exp_pix.size() * 12 + 15) / 16;
  endfunction

  task automatic wait_done(input string tag);
    int c;
    c = 0;
    while (done !== 1'b1 && c < 300) begin
      tick();
      c++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic check_words(input string tag);
    int nw;
    nw = exp_words();
    check({tag, "_nwords"}, got.size(), nw);
    for (int k = 0; k < nw; k++) begin
      if (k < got.size())
        check($sformatf("%s_w%0d", tag, k), 32'(got[k]), 32'(model_word(k)));
    end
    check({tag, "_wcount"}, 32'(word_count), nw);
    check({tag, "_ovf"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    int n;
    rst_ = 1'b0; en = 1'b0; pix_fv = 1'b0; pix_valid = 1'b0;
    pix_data = '0; fifo_ready = 1'b1;

    // Reset state
    tick(); tick();
    check("rst_trig", 32'(fifo_trigger), 0);
    check("rst_data", 32'(fifo_data), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_wc", 32'(word_count), 0);
    rst_ = 1'b1;
    tick();

    // Basic packing with one-cycle latency check
    fifo_ready = 1'b1;
    start_capture();
    put_pixel(12'hABC);
    put_pixel(12'h123);
    check("lat_trig", 32'(fifo_trigger), 1);
    check("lat_data", 32'(fifo_data), 32'h3ABC);
    put_pixel(12'h456);
    put_pixel(12'h789);
    end_frame();
    wait_done("basic");
    check_words("basic");

    // Flush of a partial word
    start_capture();
    put_pixel(12'hABC); put_pixel(12'h123); put_pixel(12'h456);
    put_pixel(12'h789); put_pixel(12'hDEF);
    end_frame();
    wait_done("flush");
    check_words("flush");

    // Backpressure with overflow, then overflow clear on re-enable
    fifo_ready = 1'b0;
    start_capture();
    put_pixel(12'hABC); put_pixel(12'h123); put_pixel(12'h456); put_pixel(12'h789);
    for (int i = 0; i < 4; i++) put_pixel(12'($urandom));
    end_frame();
    check("bp_ovf", 32'(overflow), 1);
    check("bp_wc", 32'(word_count), 2);
    check("bp_done_early", 32'(done), 0);
    check("bp_trig", 32'(fifo_trigger), 1);
    check("bp_head", 32'(fifo_data), 32'h3ABC);
    fifo_ready = 1'b1;
    wait_done("bp");
    check("bp_nwords", got.size(), 2);
    if (got.size() >= 2) begin
      check("bp_w0", 32'(got[0]), 32'h3ABC);
      check("bp_w1", 32'(got[1]), 32'h5612);
    end
    check("bp_ovf_hold", 32'(overflow), 1);
    en = 1'b0;
    tick();
    check("bp_ovf_after_en0", 32'(overflow), 1);
    check("bp_done_after_en0", 32'(done), 0);
    en = 1'b1;
    tick();
    check("bp_ovf_cleared", 32'(overflow), 0);
    check("bp_wc_cleared", 32'(word_count), 0);

    // Late enable: the frame already in progress is skipped
    en = 1'b0;
    fifo_ready = 1'b1;
    tick();
    got.delete();
    for (int i = 0; i < 3; i++) put_pixel(12'($urandom));
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      put_pixel(12'($urandom));
      check($sformatf("late_trig%0d", i), 32'(fifo_trigger), 0);
    end
    end_frame();
    tick(); tick();
    check("late_skipped", got.size(), 0);
    check("late_wc_skipped", 32'(word_count), 0);
    exp_pix.delete();
    got.delete();
    for (int i = 0; i < 6; i++) put_pixel(12'($urandom));
    end_frame();
    wait_done("late");
    check_words("late");

    // Abort mid-capture with one word queued
    fifo_ready = 1'b0;
    start_capture();
    put_pixel(12'hABC); put_pixel(12'h123);
    check("abort_trig_pre", 32'(fifo_trigger), 1);
    check("abort_wc_pre", 32'(word_count), 1);
    en = 1'b0;
    tick();
    check("abort_trig", 32'(fifo_trigger), 0);
    check("abort_data", 32'(fifo_data), 0);
    check("abort_done", 32'(done), 0);
    check("abort_wc_hold", 32'(word_count), 1);
    pix_fv = 1'b0; pix_valid = 1'b0;
    en = 1'b1;
    tick();
    check("abort_wc_clear", 32'(word_count), 0);
    check("abort_ovf_clear", 32'(overflow), 0);
    tick(); tick();
    check("abort_no_trig", 32'(fifo_trigger), 0);

    // Asynchronous reset between clock edges
    fifo_ready = 1'b1;
    start_capture();
    put_pixel(12'hABC); put_pixel(12'h123); put_pixel(12'h456);
    #2;
    rst_ = 1'b0;
    #1;
    check("arst_trig", 32'(fifo_trigger), 0);
    check("arst_data", 32'(fifo_data), 0);
    check("arst_done", 32'(done), 0);
    check("arst_ovf", 32'(overflow), 0);
    check("arst_wc", 32'(word_count), 0);
    put_pixel(12'($urandom));
    put_pixel(12'($urandom));
    rst_ = 1'b1;
    for (int i = 0; i < 5; i++) begin
      put_pixel(12'($urandom));
      check($sformatf("arst_quiet%0d", i), 32'(fifo_trigger), 0);
    end
    end_frame();
    tick(); tick();
    exp_pix.delete();
    got.delete();
    for (int i = 0; i < 5; i++) put_pixel(12'($urandom));
    end_frame();
    wait_done("post_rst");
    check_words("post_rst");

    // Randomized frames: random lengths, data and pixel gaps
    fifo_ready = 1'b1;
    for (int f = 0; f < 6; f++) begin
      start_capture();
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) begin
        if (i > 0) gap_cycles($urandom_range(0, 3));
        put_pixel(12'($urandom));
      end
      end_frame();
      wait_done($sformatf("rnd%0d", f));
      check_words($sformatf("rnd%0d", f));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
